// File: rtl/hilo_reg_file_pkg.sv
// rtl/hilo_reg_file_pkg.sv - shared constants and types for the HI/LO register file
package hilo_reg_file_pkg;

    localparam int WORD_W        = 32;
    localparam int DIV_ITERS_DEF = 32;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/hilo_div_core.sv
// rtl/hilo_div_core.sv - iterative restoring DIV/DIVU engine feeding HI/LO
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_start, i_signed     begin divide / signed select (sampled in IDLE)
//   i_dend, i_dsor        dividend / divisor (sampled in IDLE)
//   i_cancel              abort from any state, no result
//   o_busy                stall request: start cycle and all BUSY cycles
//   o_done                result valid this cycle (one cycle)
//   o_quo, o_rem          sign-corrected quotient / remainder
module hilo_div_core
    import hilo_reg_file_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int ITERS = DIV_ITERS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dend,
    input  logic [WIDTH-1:0] i_dsor,
    input  logic             i_cancel,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quo,
    output logic [WIDTH-1:0] o_rem
);

    localparam int              CNT_W    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dsor;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_dend_neg;
    logic             w_dsor_neg;
    logic [WIDTH-1:0] w_dend_abs;
    logic [WIDTH-1:0] w_dsor_abs;
    logic             w_dsor_zero;
    logic             w_go;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;

    assign w_dend_neg  = i_signed & i_dend[WIDTH-1];
    assign w_dsor_neg  = i_signed & i_dsor[WIDTH-1];
    assign w_dend_abs  = w_dend_neg ? -i_dend : i_dend;
    assign w_dsor_abs  = w_dsor_neg ? -i_dsor : i_dsor;
    assign w_dsor_zero = (i_dsor == '0);
    assign w_go        = (r_state == DIV_IDLE) & i_start & ~i_cancel;

    // r_quo holds the unconsumed dividend bits (MSB first) and collects
    // quotient bits at the LSB; the remainder never reaches WIDTH+1 bits.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dsor};
    assign w_fits  = ~w_diff[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_IDLE: if (i_start) w_state_nxt = w_dsor_zero ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (r_cnt == CNT_LAST) w_state_nxt = DIV_DONE;
            DIV_DONE: w_state_nxt = DIV_IDLE;
            default:  w_state_nxt = DIV_IDLE;
        endcase
        if (i_cancel) w_state_nxt = DIV_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_dsor  <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_go) begin
            r_cnt  <= '0;
            r_dsor <= w_dsor_abs;
            if (w_dsor_zero) begin
                // Divide by zero: preload the final answer, no sign fix-up.
                r_rem   <= i_dend;
                r_quo   <= '1;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
            end else begin
                r_rem   <= '0;
                r_quo   <= w_dend_abs;
                r_neg_q <= w_dend_neg ^ w_dsor_neg;
                r_neg_r <= w_dend_neg;
            end
        end else if ((r_state == DIV_BUSY) && !i_cancel) begin
            r_cnt <= r_cnt + 1'b1;
            r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_fits};
        end
    end

    assign o_busy = ~i_cancel & ((r_state == DIV_BUSY) |
                                 ((r_state == DIV_IDLE) & (i_start == ENABLE)));
    assign o_done = ~i_cancel & (r_state == DIV_DONE);
    assign o_quo  = r_neg_q ? -r_quo : r_quo;
    assign o_rem  = r_neg_r ? -r_rem : r_rem;

endmodule

// File: rtl/hilo_reg_file.sv
// rtl/hilo_reg_file.sv - architectural HI/LO pair with forwarding and optional divider
//
// Config macro: HILO_DIV_EN enables the divider; when undefined the div_* inputs
// are ignored and div_stall is tied low.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wb_we, wb_hi, wb_lo        WB-stage commit of HI/LO
//   mem_we, mem_hi, mem_lo     MEM-stage pending write (forwarding only)
//   div_start, div_signed      start pulse / signed select
//   div_dend, div_dsor         divide operands
//   div_cancel                 pipeline flush, abort divide
//   hi, lo                     forwarded HI/LO to EX
//   div_stall                  freeze IF..EX while dividing
module hilo_reg_file
    import hilo_reg_file_pkg::*;
#(
    parameter int WIDTH     = WORD_W,
    parameter int DIV_ITERS = DIV_ITERS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_we,
    input  logic [WIDTH-1:0] wb_hi,
    input  logic [WIDTH-1:0] wb_lo,
    input  logic             mem_we,
    input  logic [WIDTH-1:0] mem_hi,
    input  logic [WIDTH-1:0] mem_lo,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_dend,
    input  logic [WIDTH-1:0] div_dsor,
    input  logic             div_cancel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_stall
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             w_div_busy;
    logic             w_div_done;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH-1:0] w_div_rem;

`ifdef HILO_DIV_EN
    hilo_div_core #(
        .WIDTH (WIDTH),
        .ITERS (DIV_ITERS)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (div_start),
        .i_signed (div_signed),
        .i_dend   (div_dend),
        .i_dsor   (div_dsor),
        .i_cancel (div_cancel),
        .o_busy   (w_div_busy),
        .o_done   (w_div_done),
        .o_quo    (w_div_quo),
        .o_rem    (w_div_rem)
    );
`else
    logic w_unused;
    assign w_unused   = ^{div_start, div_signed, div_dend, div_dsor, div_cancel, 1'(DIV_ITERS)};
    assign w_div_busy = DISABLE;
    assign w_div_done = DISABLE;
    assign w_div_quo  = '0;
    assign w_div_rem  = '0;
`endif

    // The divide result belongs to a younger instruction than whatever is in
    // WB, so it wins a same-cycle collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_div_done) begin
            r_hi <= w_div_rem;
            r_lo <= w_div_quo;
        end else if (wb_we == ENABLE) begin
            r_hi <= wb_hi;
            r_lo <= wb_lo;
        end
    end

    always_comb begin
        hi = r_hi;
        lo = r_lo;
        if (w_div_done) begin
            hi = w_div_rem;
            lo = w_div_quo;
        end else if (mem_we) begin
            hi = mem_hi;
            lo = mem_lo;
        end else if (wb_we) begin
            hi = wb_hi;
            lo = wb_lo;
        end
    end

    assign div_stall = w_div_busy;

endmodule

// File: tb/tb_hilo_reg_file.sv
// tb/tb_hilo_reg_file.sv - self-checking bench for hilo_reg_file
module tb_hilo_reg_file;

    localparam int W     = 32;
    localparam int ITERS = 32;
`ifdef HILO_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wb_we, mem_we, div_start, div_signed, div_cancel;
    logic [W-1:0] wb_hi, wb_lo, mem_hi, mem_lo, div_dend, div_dsor;
    logic [W-1:0] hi, lo;
    logic         div_stall;

    hilo_reg_file #(.WIDTH(W), .DIV_ITERS(ITERS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_we      (wb_we),
        .wb_hi      (wb_hi),
        .wb_lo      (wb_lo),
        .mem_we     (mem_we),
        .mem_hi     (mem_hi),
        .mem_lo     (mem_lo),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_dend   (div_dend),
        .div_dsor   (div_dsor),
        .div_cancel (div_cancel),
        .hi         (hi),
        .lo         (lo),
        .div_stall  (div_stall)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural HI/LO plus one in-flight divide
    // described by its elapsed cycle count and the cycle its result lands.
    logic [W-1:0] m_hi, m_lo, m_q, m_r;
    bit           m_act;
    int           m_t, m_end;
    int           stall_cnt;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic div_ref(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic idle_inputs();
        wb_we = 0; mem_we = 0; div_start = 0; div_signed = 0; div_cancel = 0;
        wb_hi = '0; wb_lo = '0; mem_hi = '0; mem_lo = '0; div_dend = '0; div_dsor = '0;
    endtask

    task automatic model_reset();
        m_hi = '0; m_lo = '0; m_act = 0; m_t = 0; m_end = 0;
    endtask

    // Called at the negedge with inputs for this cycle already applied.
    task automatic cycle();
        logic [W-1:0] eh, el;
        bit done_now, busy_now;
        #1;
        done_now = m_act && (m_t == m_end) && !div_cancel;
        busy_now = !div_cancel && ((m_act && m_t < m_end) || (!m_act && DIV_EN && div_start));
        eh = done_now ? m_r : mem_we ? mem_hi : wb_we ? wb_hi : m_hi;
        el = done_now ? m_q : mem_we ? mem_lo : wb_we ? wb_lo : m_lo;
        check("hi", hi, eh);
        check("lo", lo, el);
        check("stall", W'(div_stall), W'(busy_now));
        if (div_stall) stall_cnt++;
        @(posedge clk);
        if (done_now) begin
            m_hi = m_r; m_lo = m_q;
        end else if (wb_we) begin
            m_hi = wb_hi; m_lo = wb_lo;
        end
        if (div_cancel) begin
            m_act = 0;
        end else if (m_act) begin
            if (m_t == m_end) m_act = 0;
            else m_t++;
        end else if (DIV_EN && div_start) begin
            m_act = 1;
            m_t   = 1;
            m_end = (div_dsor == '0) ? 1 : ITERS + 1;
            div_ref(div_signed, div_dend, div_dsor, m_q, m_r);
        end
        @(negedge clk);
    endtask

    // Issues a divide and returns at the negedge opening its DONE cycle.
    task automatic run_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        idle_inputs();
        div_start = 1; div_signed = sgn; div_dend = a; div_dsor = b;
        stall_cnt = 0;
        cycle();
        idle_inputs();
        for (int i = 0; i < 100 && m_act && m_t != m_end; i++) cycle();
    endtask

    task automatic wb_write(input logic [W-1:0] h, input logic [W-1:0] l);
        idle_inputs();
        wb_we = 1; wb_hi = h; wb_lo = l;
        cycle();
        idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        #1;
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);
        check("rst_stall", W'(div_stall), '0);
        @(negedge clk);
        rst_n = 1;
        cycle();

        // MEM pending beats WB pending; next cycle the WB value is in the regs.
        wb_we = 1; wb_hi = 32'h1234; wb_lo = 32'h5678;
        mem_we = 1; mem_hi = 32'hAAAA; mem_lo = 32'hBBBB;
        #1;
        check("fwd_mem_hi", hi, 32'hAAAA);
        check("fwd_mem_lo", lo, 32'hBBBB);
        cycle();
        idle_inputs();
        #1;
        check("reg_hi", hi, 32'h1234);
        check("reg_lo", lo, 32'h5678);
        cycle();

        run_div(0, 32'd100, 32'd7);
`ifdef HILO_DIV_EN
        #1;
        check("divu_stall_cycles", W'(stall_cnt), W'(33));
        check("divu_done_lo", lo, 32'd14);
        check("divu_done_hi", hi, 32'd2);
        check("divu_done_stall", W'(div_stall), '0);
`endif
        cycle();
        cycle();

        run_div(1, -32'sd7, 32'd2);
        cycle();
`ifdef HILO_DIV_EN
        #1;
        check("div_m7_2_lo", lo, 32'hFFFF_FFFD);
        check("div_m7_2_hi", hi, 32'hFFFF_FFFF);
`endif
        run_div(1, 32'd7, -32'sd2);
        cycle();
`ifdef HILO_DIV_EN
        #1;
        check("div_7_m2_lo", lo, 32'hFFFF_FFFD);
        check("div_7_m2_hi", hi, 32'd1);
`endif
        run_div(1, 32'h8000_0000, 32'hFFFF_FFFF);
        cycle();
`ifdef HILO_DIV_EN
        #1;
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'd0);
`endif
        run_div(0, 32'h55, 32'd0);
`ifdef HILO_DIV_EN
        #1;
        check("div0_stall_cycles", W'(stall_cnt), W'(1));
        check("div0_hi", hi, 32'h55);
        check("div0_lo", lo, 32'hFFFF_FFFF);
`endif
        cycle();

        // Cancel at BUSY count 10: no write, registers keep their value.
        wb_write(32'hC0FFEE, 32'hF00D);
        idle_inputs();
        div_start = 1; div_dend = 32'd999; div_dsor = 32'd3;
        cycle();
        idle_inputs();
        for (int i = 0; i < 10; i++) cycle();
        div_cancel = 1;
        #1;
        check("cancel_stall", W'(div_stall), '0);
        cycle();
        idle_inputs();
        for (int i = 0; i < 40; i++) cycle();
        #1;
        check("cancel_hi_kept", hi, 32'hC0FFEE);
        check("cancel_lo_kept", lo, 32'hF00D);

        // WB write landing in the DONE cycle loses to the divide result.
        run_div(0, 32'd1000, 32'd10);
        wb_we = 1; wb_hi = 32'hDEAD; wb_lo = 32'hBEEF;
        cycle();
        idle_inputs();
        #1;
`ifdef HILO_DIV_EN
        check("done_vs_wb_lo", lo, 32'd100);
        check("done_vs_wb_hi", hi, 32'd0);
`else
        check("wb_only_lo", lo, 32'hBEEF);
        check("wb_only_hi", hi, 32'hDEAD);
`endif
        cycle();

        // Reset in the middle of a divide.
        wb_write(32'h1111, 32'h2222);
        div_start = 1; div_dend = 32'd100; div_dsor = 32'd7;
        cycle();
        idle_inputs();
        for (int i = 0; i < 5; i++) cycle();
        rst_n = 0;
        #1;
        check("midrst_hi", hi, '0);
        check("midrst_lo", lo, '0);
        check("midrst_stall", W'(div_stall), '0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 40; i++) cycle();

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            idle_inputs();
            wb_we  = 1'($urandom_range(0, 1));
            wb_hi  = $urandom; wb_lo = $urandom;
            mem_we = ($urandom_range(0, 3) == 0);
            mem_hi = $urandom; mem_lo = $urandom;
            if (!m_act && $urandom_range(0, 11) == 0) begin
                div_start  = 1;
                div_signed = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0: begin div_dend = $urandom; div_dsor = $urandom; end
                    1: begin div_dend = $urandom; div_dsor = '0; end
                    2: begin div_dend = 32'h8000_0000; div_dsor = '1; end
                    default: begin div_dend = $urandom; div_dsor = W'($urandom_range(1, 300)); end
                endcase
            end
            div_cancel = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
